// File: rtl/rv32i_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_alu_pkg
// Brief    : Shared widths, op-vector bit indices and FSM encoding for the
//            RV32I ALU sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package rv32i_alu_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int NUM_ALU_OPS  = 10;
    localparam int NUM_BR_OPS   = 6;
    localparam int OPV_W        = NUM_ALU_OPS + NUM_BR_OPS;

    // One-hot bit positions inside op_alu_i
    localparam int OP_ADD  = 0;
    localparam int OP_SUB  = 1;
    localparam int OP_SLL  = 2;
    localparam int OP_SLT  = 3;
    localparam int OP_SLTU = 4;
    localparam int OP_XOR  = 5;
    localparam int OP_SRL  = 6;
    localparam int OP_SRA  = 7;
    localparam int OP_OR   = 8;
    localparam int OP_AND  = 9;

    // One-hot bit positions inside op_br_i
    localparam int BR_BEQ  = 0;
    localparam int BR_BNE  = 1;
    localparam int BR_BLT  = 2;
    localparam int BR_BGE  = 3;
    localparam int BR_BLTU = 4;
    localparam int BR_BGEU = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef logic [OPV_W-1:0] opv_t;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero
    function automatic logic is_onehot(input opv_t v);
        return (v != '0) && ((v & (v - opv_t'(1))) == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv32i_alu_step.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_alu_step
// Brief    : Combinational datapath: single-cycle ALU/branch result and one
//            shift step of up to SHIFT_STEP bits.
// Revision : 1.0 - initial release
// ============================================================================
module rv32i_alu_step
    import rv32i_alu_pkg::*;
#(
    parameter int XLEN       = XLEN_DEFAULT,
    parameter int SHIFT_STEP = 1,
    localparam int STEP_W    = $clog2(SHIFT_STEP + 1)
) (
    input  logic [NUM_ALU_OPS-1:0] op_alu_i,
    input  logic [NUM_BR_OPS-1:0]  op_br_i,
    input  logic [XLEN-1:0]        a_i,
    input  logic [XLEN-1:0]        b_i,
    input  logic [XLEN-1:0]        acc_i,
    input  logic [STEP_W-1:0]      step_amt_i,
    input  logic                   shift_left_i,
    input  logic                   shift_arith_i,
    output logic [XLEN-1:0]        result_o,
    output logic                   br_taken_o,
    output logic [XLEN-1:0]        shift_o
);

    logic [XLEN-1:0] w_sum;
    logic [XLEN-1:0] w_diff;
    logic            w_lt_s;
    logic            w_lt_u;
    logic            w_eq;
    logic            w_is_shift;

    assign w_sum      = a_i + b_i;
    assign w_diff     = a_i - b_i;
    assign w_lt_s     = $signed(a_i) < $signed(b_i);
    assign w_lt_u     = a_i < b_i;
    assign w_eq       = (a_i == b_i);
    assign w_is_shift = op_alu_i[OP_SLL] | op_alu_i[OP_SRL] | op_alu_i[OP_SRA];

    // AND-OR select; a zero-amount shift passes operand A through unchanged
    assign result_o = ({XLEN{op_alu_i[OP_ADD]}}  & w_sum)
                    | ({XLEN{op_alu_i[OP_SUB]}}  & w_diff)
                    | ({XLEN{op_alu_i[OP_SLT]}}  & {{(XLEN-1){1'b0}}, w_lt_s})
                    | ({XLEN{op_alu_i[OP_SLTU]}} & {{(XLEN-1){1'b0}}, w_lt_u})
                    | ({XLEN{op_alu_i[OP_XOR]}}  & (a_i ^ b_i))
                    | ({XLEN{op_alu_i[OP_OR]}}   & (a_i | b_i))
                    | ({XLEN{op_alu_i[OP_AND]}}  & (a_i & b_i))
                    | ({XLEN{w_is_shift}}        & a_i);

    assign br_taken_o = (op_br_i[BR_BEQ]  &  w_eq)
                      | (op_br_i[BR_BNE]  & ~w_eq)
                      | (op_br_i[BR_BLT]  &  w_lt_s)
                      | (op_br_i[BR_BGE]  & ~w_lt_s)
                      | (op_br_i[BR_BLTU] &  w_lt_u)
                      | (op_br_i[BR_BGEU] & ~w_lt_u);

    always_comb begin
        shift_o = acc_i;
        if (shift_left_i) begin
            shift_o = acc_i << step_amt_i;
        end else if (shift_arith_i) begin
            shift_o = $unsigned($signed(acc_i) >>> step_amt_i);
        end else begin
            shift_o = acc_i >> step_amt_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rv32i_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_alu_seq
// Brief    : Multi-cycle ALU/branch sequencer; shifts iterate SHIFT_STEP bits
//            per cycle, everything else completes in one cycle.
// Revision : 1.0 - initial release
// ============================================================================
module rv32i_alu_seq
    import rv32i_alu_pkg::*;
#(
    parameter int XLEN       = XLEN_DEFAULT,
    parameter int SHIFT_STEP = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [NUM_ALU_OPS-1:0] op_alu_i,
    input  logic [NUM_BR_OPS-1:0]  op_br_i,
    input  logic [XLEN-1:0]        a_i,
    input  logic [XLEN-1:0]        b_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [XLEN-1:0]        result_o,
    output logic                   br_taken_o,
    output logic                   err_o,
    output logic                   busy_o
);

    localparam int c_shamt_w   = $clog2(XLEN);
    localparam int c_step_w    = $clog2(SHIFT_STEP + 1);
    localparam int c_step_log2 = $clog2(SHIFT_STEP);
    localparam logic [c_shamt_w-1:0] c_step_sh  = c_shamt_w'(SHIFT_STEP);
    localparam logic [c_step_w-1:0]  c_step_amt = c_step_w'(SHIFT_STEP);

    state_t                r_state;
    logic [c_shamt_w-1:0]  r_cnt;
    logic [c_shamt_w-1:0]  r_rem;
    logic [XLEN-1:0]       r_acc;
    logic                  r_br;
    logic                  r_err;
    logic                  r_shift_left;
    logic                  r_shift_arith;

    state_t                w_state_nxt;
    logic [c_shamt_w-1:0]  w_cnt_nxt;
    logic [c_shamt_w-1:0]  w_rem_nxt;
    logic [XLEN-1:0]       w_acc_nxt;
    logic                  w_br_nxt;
    logic                  w_err_nxt;
    logic                  w_left_nxt;
    logic                  w_arith_nxt;

    logic                  w_onehot;
    logic                  w_is_shift;
    logic [c_shamt_w-1:0]  w_shamt;
    logic [c_shamt_w:0]    w_ceil_sum;
    logic [c_shamt_w-1:0]  w_cnt_init;
    logic [c_step_w-1:0]   w_step_amt;
    logic [XLEN-1:0]       w_alu_result;
    logic                  w_br_taken;
    logic [XLEN-1:0]       w_shift_out;
    logic                  w_done;

    assign w_onehot   = is_onehot({op_alu_i, op_br_i});
    assign w_is_shift = op_alu_i[OP_SLL] | op_alu_i[OP_SRL] | op_alu_i[OP_SRA];
    assign w_shamt    = b_i[c_shamt_w-1:0];
    assign w_ceil_sum = {1'b0, w_shamt} + (c_shamt_w + 1)'(SHIFT_STEP - 1);
    assign w_cnt_init = c_shamt_w'(w_ceil_sum >> c_step_log2);

    // Final step only moves the leftover bits so shamt need not be a STEP multiple
    assign w_step_amt = (r_rem >= c_step_sh) ? c_step_amt : r_rem[c_step_w-1:0];

    rv32i_alu_step #(
        .XLEN       (XLEN),
        .SHIFT_STEP (SHIFT_STEP)
    ) u_step (
        .op_alu_i      (op_alu_i),
        .op_br_i       (op_br_i),
        .a_i           (a_i),
        .b_i           (b_i),
        .acc_i         (r_acc),
        .step_amt_i    (w_step_amt),
        .shift_left_i  (r_shift_left),
        .shift_arith_i (r_shift_arith),
        .result_o      (w_alu_result),
        .br_taken_o    (w_br_taken),
        .shift_o       (w_shift_out)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_rem         <= '0;
            r_acc         <= '0;
            r_br          <= 1'b0;
            r_err         <= 1'b0;
            r_shift_left  <= 1'b0;
            r_shift_arith <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_rem         <= w_rem_nxt;
            r_acc         <= w_acc_nxt;
            r_br          <= w_br_nxt;
            r_err         <= w_err_nxt;
            r_shift_left  <= w_left_nxt;
            r_shift_arith <= w_arith_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rem_nxt   = r_rem;
        w_acc_nxt   = r_acc;
        w_br_nxt    = r_br;
        w_err_nxt   = r_err;
        w_left_nxt  = r_shift_left;
        w_arith_nxt = r_shift_arith;
        case (r_state)
            IDLE: begin
                if (req_valid_i) begin
                    w_left_nxt  = op_alu_i[OP_SLL];
                    w_arith_nxt = op_alu_i[OP_SRA];
                    w_err_nxt   = 1'b0;
                    w_br_nxt    = 1'b0;
                    if (!w_onehot) begin
                        w_acc_nxt   = '0;
                        w_err_nxt   = 1'b1;
                        w_state_nxt = DONE;
                    end else if (w_is_shift && (w_shamt != '0)) begin
                        w_acc_nxt   = a_i;
                        w_cnt_nxt   = w_cnt_init;
                        w_rem_nxt   = w_shamt;
                        w_state_nxt = SHIFT;
                    end else begin
                        w_acc_nxt   = w_alu_result;
                        w_br_nxt    = w_br_taken;
                        w_state_nxt = DONE;
                    end
                end
            end
            SHIFT: begin
                w_acc_nxt = w_shift_out;
                w_cnt_nxt = r_cnt - c_shamt_w'(1);
                w_rem_nxt = r_rem - c_shamt_w'(w_step_amt);
                if (r_cnt == c_shamt_w'(1)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (rsp_ready_i) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_done      = (r_state == DONE);
    assign req_ready_o = (r_state == IDLE);
    assign busy_o      = ~req_ready_o;
    assign rsp_valid_o = w_done;
    assign result_o    = w_done ? r_acc : '0;
    assign br_taken_o  = w_done & r_br;
    assign err_o       = w_done & r_err;

endmodule
`default_nettype wire
